zap_wb_ram_responder: RTL and testbench



---
 rtl/zap_wb_ram_responder.sv | 141 ++++++++++++++
 tb/tb_zap_wb_ram_responder.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/zap_wb_ram_responder.sv
// Wishbone B3 responder backed by a word-addressed RAM.
// Handles classic and incrementing-burst cycles, programmable wait states and ERR+ACK for out-of-window beats.
module zap_wb_ram_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_wb_cyc,
    input  logic        i_wb_stb,
    input  logic [31:0] i_wb_adr,
    input  logic        i_wb_wen,
    input  logic [3:0]  i_wb_sel,
    input  logic [31:0] i_wb_dat,
    input  logic [2:0]  i_wb_cti,
    output logic [31:0] o_wb_dat,
    output logic        o_wb_ack,
    output logic        o_wb_err
);
    localparam int unsigned AW        = $clog2(DEPTH_WORDS);
    localparam logic [32:0] WIN_BYTES = 33'(DEPTH_WORDS) * 33'd4;
    localparam logic [3:0]  CNT_INIT  = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
    localparam logic [2:0]  CTI_INCR  = 3'b010;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] adr_q, adr_d;
    logic          wen_q, wen_d;
    logic [2:0]    cti_q, cti_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          errp_q, errp_d;
    logic          ack_q, ack_d;
    logic          err_q, err_d;
    logic [31:0]   dat_q, dat_d;

    logic [31:0]   mem [DEPTH_WORDS];
    logic [31:0]   win_off;
    logic          in_win;
    logic          wr_en;

    // BASE_ADDR is window-aligned, so the low address bits index the RAM directly.
    assign win_off = i_wb_adr - BASE_ADDR;
    assign in_win  = {1'b0, win_off} < WIN_BYTES;

    always_comb begin
        state_d = state_q;
        adr_d   = adr_q;
        wen_d   = wen_q;
        cti_d   = cti_q;
        cnt_d   = cnt_q;
        errp_d  = errp_q;
        case (state_q)
            S_IDLE: begin
                if (i_wb_cyc && i_wb_stb) begin
                    adr_d  = i_wb_adr[AW+1:2];
                    wen_d  = i_wb_wen;
                    cti_d  = i_wb_cti;
                    errp_d = !in_win;
                    if (WAIT_STATES == 0) begin
                        state_d = S_ACK;
                    end else begin
                        cnt_d   = CNT_INIT;
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (!i_wb_cyc) begin
                    state_d = S_IDLE;
                end else if (cnt_q == 4'd0) begin
                    state_d = S_ACK;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_ACK: begin
                // Burst continuation wraps inside the window, so later beats never error.
                if (cti_q == CTI_INCR && i_wb_cyc) begin
                    adr_d  = adr_q + AW'(1);
                    cti_d  = i_wb_cti;
                    errp_d = 1'b0;
                    if (WAIT_STATES == 0) begin
                        state_d = S_ACK;
                    end else begin
                        cnt_d   = CNT_INIT;
                        state_d = S_WAIT;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are computed for the upcoming cycle so they leave the block registered.
        ack_d = (state_d == S_ACK);
        err_d = ack_d && errp_d;
        dat_d = (ack_d && !wen_d && !errp_d) ? mem[adr_d] : 32'd0;
    end

    assign wr_en = (state_q == S_ACK) && wen_q && !errp_q;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= S_IDLE;
            adr_q   <= '0;
            wen_q   <= 1'b0;
            cti_q   <= 3'd0;
            cnt_q   <= 4'd0;
            errp_q  <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            dat_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
            wen_q   <= wen_d;
            cti_q   <= cti_d;
            cnt_q   <= cnt_d;
            errp_q  <= errp_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            dat_q   <= dat_d;
        end
    end

    // RAM contents survive reset; wr_en is already cleared by the asynchronous state reset.
    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (i_wb_sel[b]) mem[adr_q][8*b +: 8] <= i_wb_dat[8*b +: 8];
            end
        end
    end

    assign o_wb_ack = ack_q;
    assign o_wb_err = err_q;
    assign o_wb_dat = dat_q;
endmodule

// File: tb/tb_zap_wb_ram_responder.sv
// Directed bench: one responder with no wait states, one with three, sharing all bus inputs except CYC.
module tb_zap_wb_ram_responder;
    localparam logic [31:0] BASE = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cyc_a, cyc_b, stb, wen;
    logic [31:0] adr, wdat;
    logic [3:0]  sel;
    logic [2:0]  cti;
    logic [31:0] dat_a, dat_b;
    logic        ack_a, ack_b, err_a, err_b;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    zap_wb_ram_responder #(.DEPTH_WORDS(16), .BASE_ADDR(BASE), .WAIT_STATES(0)) dut_a (
        .i_clk(clk), .i_reset_n(rst_n), .i_wb_cyc(cyc_a), .i_wb_stb(stb), .i_wb_adr(adr),
        .i_wb_wen(wen), .i_wb_sel(sel), .i_wb_dat(wdat), .i_wb_cti(cti),
        .o_wb_dat(dat_a), .o_wb_ack(ack_a), .o_wb_err(err_a)
    );

    zap_wb_ram_responder #(.DEPTH_WORDS(16), .BASE_ADDR(BASE), .WAIT_STATES(3)) dut_b (
        .i_clk(clk), .i_reset_n(rst_n), .i_wb_cyc(cyc_b), .i_wb_stb(stb), .i_wb_adr(adr),
        .i_wb_wen(wen), .i_wb_sel(sel), .i_wb_dat(wdat), .i_wb_cti(cti),
        .o_wb_dat(dat_b), .o_wb_ack(ack_b), .o_wb_err(err_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic bus_idle();
        cyc_a = 1'b0; cyc_b = 1'b0; stb = 1'b0; wen = 1'b0;
        adr = 32'd0; wdat = 32'd0; sel = 4'd0; cti = 3'd0;
    endtask

    task automatic set_req(input logic [31:0] a, input logic w, input logic [3:0] s,
                           input logic [31:0] d, input logic [2:0] c);
        stb = 1'b1; adr = a; wen = w; sel = s; wdat = d; cti = c;
    endtask

    // Classic transfer on the zero-wait responder: ACK the cycle after the request, then a gap.
    task automatic xfer_a(input string tag, input logic [31:0] a, input logic w, input logic [3:0] s,
                          input logic [31:0] d, input logic [31:0] exp_dat, input logic exp_err);
        set_req(a, w, s, d, 3'b000);
        cyc_a = 1'b1;
        tick();
        chk({tag, "/ack"}, 32'(ack_a), 32'd1);
        chk({tag, "/err"}, 32'(err_a), 32'(exp_err));
        chk({tag, "/dat"}, dat_a, exp_dat);
        tick();
        chk({tag, "/gap"}, 32'(ack_a), 32'd0);
        bus_idle();
    endtask

    // Classic transfer on the three-wait responder: ACK exactly four cycles after the request edge.
    task automatic xfer_b(input string tag, input logic [31:0] a, input logic w,
                          input logic [31:0] d, input logic [31:0] exp_dat);
        set_req(a, w, 4'hF, d, 3'b000);
        cyc_b = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk({tag, "/wait"}, 32'(ack_b), 32'd0);
        end
        tick();
        chk({tag, "/ack"}, 32'(ack_b), 32'd1);
        chk({tag, "/dat"}, dat_b, exp_dat);
        tick();
        chk({tag, "/gap"}, 32'(ack_b), 32'd0);
        bus_idle();
    endtask

    initial begin
        rst_n = 1'b0;
        bus_idle();
        tick();
        tick();
        chk("rst/ack_a", 32'(ack_a), 32'd0);
        chk("rst/err_a", 32'(err_a), 32'd0);
        chk("rst/dat_a", dat_a, 32'd0);
        chk("rst/ack_b", 32'(ack_b), 32'd0);
        rst_n = 1'b1;
        tick();

        xfer_a("wr10", BASE + 32'h10, 1'b1, 4'hF, 32'hDEAD_BEEF, 32'd0, 1'b0);
        xfer_a("rd10", BASE + 32'h10, 1'b0, 4'h0, 32'd0, 32'hDEAD_BEEF, 1'b0);

        // CYC without STB must be ignored.
        cyc_a = 1'b1; adr = BASE + 32'h10;
        tick();
        tick();
        chk("nostb/ack", 32'(ack_a), 32'd0);
        bus_idle();

        xfer_a("pre14", BASE + 32'h14, 1'b1, 4'hF, 32'h1122_3344, 32'd0, 1'b0);
        xfer_a("lane14", BASE + 32'h14, 1'b1, 4'b0101, 32'hAABB_CCDD, 32'd0, 1'b0);
        xfer_a("rd14", BASE + 32'h14, 1'b0, 4'h0, 32'd0, 32'h11BB_33DD, 1'b0);

        for (int i = 0; i < 4; i++)
            xfer_a("pre_burst", BASE + 32'(4 * i), 1'b1, 4'hF, 32'(i + 1), 32'd0, 1'b0);

        // Four-beat read burst; the next beat's CTI is presented during each ACK cycle.
        set_req(BASE, 1'b0, 4'h0, 32'd0, 3'b010);
        cyc_a = 1'b1;
        tick();
        chk("burst/ack1", 32'(ack_a), 32'd1);
        chk("burst/dat1", dat_a, 32'd1);
        cti = 3'b010;
        tick();
        chk("burst/ack2", 32'(ack_a), 32'd1);
        chk("burst/dat2", dat_a, 32'd2);
        cti = 3'b010;
        tick();
        chk("burst/ack3", 32'(ack_a), 32'd1);
        chk("burst/dat3", dat_a, 32'd3);
        cti = 3'b111;
        tick();
        chk("burst/ack4", 32'(ack_a), 32'd1);
        chk("burst/dat4", dat_a, 32'd4);
        tick();
        chk("burst/end_ack", 32'(ack_a), 32'd0);
        chk("burst/end_dat", dat_a, 32'd0);
        bus_idle();

        xfer_b("ws_wr20", BASE + 32'h20, 1'b1, 32'hCAFE_F00D, 32'd0);
        xfer_b("ws_rd20", BASE + 32'h20, 1'b0, 32'd0, 32'hCAFE_F00D);

        // Abort: drop CYC while waiting, no ACK may follow.
        set_req(BASE + 32'h20, 1'b0, 4'h0, 32'd0, 3'b000);
        cyc_b = 1'b1;
        tick();
        tick();
        bus_idle();
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("abort/ack", 32'(ack_b), 32'd0);
        end
        xfer_b("ws_after_abort", BASE + 32'h20, 1'b0, 32'd0, 32'hCAFE_F00D);

        xfer_a("err_rd_hi", BASE + 32'h40, 1'b0, 4'h0, 32'd0, 32'd0, 1'b1);
        chk("err_rd_hi/clr", 32'(err_a), 32'd0);
        xfer_a("err_rd_lo", BASE - 32'h4, 1'b0, 4'h0, 32'd0, 32'd0, 1'b1);
        xfer_a("err_wr_hi", BASE + 32'h40, 1'b1, 4'hF, 32'h1234_5678, 32'd0, 1'b1);
        xfer_a("err_wr_chk", BASE, 1'b0, 4'h0, 32'd0, 32'd1, 1'b0);

        // Asynchronous reset in the middle of a read burst.
        set_req(BASE, 1'b0, 4'h0, 32'd0, 3'b010);
        cyc_a = 1'b1;
        tick();
        chk("rstb/dat1", dat_a, 32'd1);
        tick();
        chk("rstb/dat2", dat_a, 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstb/ack", 32'(ack_a), 32'd0);
        chk("rstb/err", 32'(err_a), 32'd0);
        chk("rstb/dat", dat_a, 32'd0);
        bus_idle();
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        xfer_a("post_rst_rd4", BASE + 32'h4, 1'b0, 4'h0, 32'd0, 32'd2, 1'b0);
        xfer_a("post_rst_rd14", BASE + 32'h14, 1'b0, 4'h0, 32'd0, 32'h11BB_33DD, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
